probe_buffer_reader: RTL and testbench

Synthesizable counterpart of the behavioural probe-buffer sink: a FIFO that captures 64-bit probe words written by the core and returns them to a core-side reader in write order, head first. It uses the same `write`/`wen`/`read` port triple as the sink, adds a pop strobe and status outputs, and sits in the tile next to the probe CSR decode. Unlike the sink, `read` returns real data (the FIFO head) instead of constant zero.

---
 rtl/probe_pkg.sv | 18 +
 rtl/probe_fifo_mem.sv | 28 ++
 rtl/probe_buffer_reader.sv | 94 +++++++++
 tb/tb_probe_buffer_reader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/probe_pkg.sv
// Shared constants and types for the probe buffer reader.
// Holds probe word widths and drop-counter saturation limits.
package probe_pkg;

    localparam int PROBE_WIDTH      = 64;
    localparam int PROBE_DROP_CNT_W = 16;

    localparam logic [PROBE_DROP_CNT_W-1:0] PROBE_DROP_MAX = 16'hFFFF;

    typedef logic [PROBE_WIDTH-1:0] probe_word_t;

    function automatic logic [PROBE_DROP_CNT_W-1:0] drop_sat_inc(
        input logic [PROBE_DROP_CNT_W-1:0] v
    );
        return (v == PROBE_DROP_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/probe_fifo_mem.sv
// Probe FIFO storage: register array, one sync write port,
// one async read port, no reset.
module probe_fifo_mem
    import probe_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = PROBE_WIDTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/probe_buffer_reader.sv
// Probe FIFO: captures core probe words and returns them head first,
// with sticky overflow flag and saturating drop counter.
module probe_buffer_reader
    import probe_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = PROBE_WIDTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            write,
    input  logic                        wen,
    input  logic                        ren,
    input  logic                        flush,
    output logic [WIDTH-1:0]            read,
    output logic                        empty,
    output logic                        full,
    output logic [CW-1:0]               count,
    output logic                        overflow,
    output logic [PROBE_DROP_CNT_W-1:0] drop_count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [CW-1:0]               count_q;
    logic                        overflow_q;
    logic [PROBE_DROP_CNT_W-1:0] drop_q;
    logic [WIDTH-1:0]            head;
    logic                        push;
    logic                        pop;
    logic                        drop;
    logic                        mem_we;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    assign push   = wen && (!full || ren);
    assign pop    = ren && !empty;
    assign drop   = wen && full && !ren;
    // flush and reset suppress the write so pointers and data stay in step
    assign mem_we = push && !flush && !reset;

    probe_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (write),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
                drop_q     <= drop_sat_inc(drop_q);
            end
        end
    end

    assign read       = empty ? '0 : head;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_probe_buffer_reader.sv
// Directed-vector bench for probe_buffer_reader.
// One task per scenario, inline comparisons, single summary line.
module tb_probe_buffer_reader;

    logic        clock;
    logic        reset;
    logic [63:0] write;
    logic        wen;
    logic        ren;
    logic        flush;
    logic [63:0] read;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_count;

    int n_cmp;
    int n_bad;

    probe_buffer_reader #(
        .DEPTH (16),
        .WIDTH (64)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .write      (write),
        .wen        (wen),
        .ren        (ren),
        .flush      (flush),
        .read       (read),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wen   = 1'b0;
        ren   = 1'b0;
        flush = 1'b0;
        write = '0;
    endtask

    task automatic push(input logic [63:0] v);
        wen   = 1'b1;
        write = v;
        tick();
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_status got c=%0d e=%b f=%b want c=0 e=1 f=0",
                     count, empty, full);
        end
        n_cmp++;
        if (read !== 64'd0 || overflow !== 1'b0 || drop_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_out got rd=%h ov=%b dc=%h want 0/0/0",
                     read, overflow, drop_count);
        end
    endtask

    task automatic test_basic();
        logic [63:0] exp [3];
        exp[0] = 64'h1111;
        exp[1] = 64'h2222;
        exp[2] = 64'h3333;
        for (int i = 0; i < 3; i++) push(exp[i]);
        n_cmp++;
        if (count !== 5'd3 || read !== 64'h1111) begin
            n_bad++;
            $display("FAIL basic_fill got c=%0d rd=%h want c=3 rd=1111",
                     count, read);
        end
        ren = 1'b1;
        for (int i = 1; i < 3; i++) begin
            tick();
            n_cmp++;
            if (read !== exp[i]) begin
                n_bad++;
                $display("FAIL basic_pop%0d got %h want %h", i, read, exp[i]);
            end
        end
        tick();
        idle();
        n_cmp++;
        if (empty !== 1'b1 || read !== 64'd0) begin
            n_bad++;
            $display("FAIL basic_empty got e=%b rd=%h want e=1 rd=0",
                     empty, read);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) push(64'(i));
        push(64'hDEAD);
        n_cmp++;
        if (full !== 1'b1 || overflow !== 1'b1 || drop_count !== 16'd1) begin
            n_bad++;
            $display("FAIL ovf_flags got f=%b ov=%b dc=%0d want 1/1/1",
                     full, overflow, drop_count);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (read !== 64'(i)) begin
                n_bad++;
                $display("FAIL ovf_drain%0d got %h want %h", i, read, 64'(i));
            end
            ren = 1'b1;
            tick();
            idle();
        end
        n_cmp++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            n_bad++;
            $display("FAIL ovf_end got e=%b c=%0d want e=1 c=0", empty, count);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 16; i++) push(64'(i));
        wen   = 1'b1;
        ren   = 1'b1;
        write = 64'hBEEF;
        tick();
        idle();
        n_cmp++;
        if (count !== 5'd16 || drop_count !== 16'd1 || read !== 64'd1) begin
            n_bad++;
            $display("FAIL full_rw got c=%0d dc=%0d rd=%h want 16/1/1",
                     count, drop_count, read);
        end
        for (int i = 1; i < 17; i++) begin
            logic [63:0] e;
            e = (i == 16) ? 64'hBEEF : 64'(i);
            n_cmp++;
            if (read !== e) begin
                n_bad++;
                $display("FAIL full_rw_drain%0d got %h want %h", i, read, e);
            end
            ren = 1'b1;
            tick();
            idle();
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_bad++;
            $display("FAIL full_rw_end got e=%b want 1", empty);
        end
    endtask

    task automatic test_empty_rw();
        wen   = 1'b1;
        ren   = 1'b1;
        write = 64'h42;
        tick();
        idle();
        n_cmp++;
        if (count !== 5'd1 || read !== 64'h42) begin
            n_bad++;
            $display("FAIL empty_rw got c=%0d rd=%h want c=1 rd=42",
                     count, read);
        end
        ren = 1'b1;
        tick();
        tick();
        idle();
        n_cmp++;
        if (count !== 5'd0 || empty !== 1'b1 || read !== 64'd0 ||
            overflow !== 1'b1 || drop_count !== 16'd1) begin
            n_bad++;
            $display("FAIL empty_ren got c=%0d e=%b rd=%h ov=%b dc=%0d want 0/1/0/1/1",
                     count, empty, read, overflow, drop_count);
        end
        push(64'h77);
        n_cmp++;
        if (count !== 5'd1 || read !== 64'h77) begin
            n_bad++;
            $display("FAIL empty_ren_after got c=%0d rd=%h want c=1 rd=77",
                     count, read);
        end
        ren = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 16; i++) push(64'(100 + i));
        wen   = 1'b1;
        write = 64'hBAD;
        for (int i = 0; i < 65533; i++) tick();
        n_cmp++;
        if (drop_count !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL sat_pre got %h want fffe", drop_count);
        end
        tick();
        n_cmp++;
        if (drop_count !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_hit got %h want ffff", drop_count);
        end
        for (int i = 0; i < 70000 - 65534; i++) tick();
        n_cmp++;
        if (drop_count !== 16'hFFFF || count !== 5'd16 || read !== 64'd100) begin
            n_bad++;
            $display("FAIL sat_hold got dc=%h c=%0d rd=%h want ffff/16/64",
                     drop_count, count, read);
        end
        ren   = 1'b1;
        flush = 1'b1;
        tick();
        idle();
        n_cmp++;
        if (count !== 5'd0 || empty !== 1'b1 || read !== 64'd0 ||
            overflow !== 1'b1 || drop_count !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL flush got c=%0d e=%b rd=%h ov=%b dc=%h want 0/1/0/1/ffff",
                     count, empty, read, overflow, drop_count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push(64'(200 + i));
        reset = 1'b1;
        wen   = 1'b1;
        write = 64'h5A5A;
        tick();
        reset = 1'b0;
        idle();
        n_cmp++;
        if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 ||
            drop_count !== 16'd0 || read !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_mid got c=%0d e=%b ov=%b dc=%0d rd=%h want 0/1/0/0/0",
                     count, empty, overflow, drop_count, read);
        end
        for (int i = 0; i < 20; i++) begin
            logic [63:0] v;
            v = 64'hA000 + 64'(i * 3);
            push(v);
            n_cmp++;
            if (read !== v || count !== 5'd1) begin
                n_bad++;
                $display("FAIL wrap%0d got rd=%h c=%0d want rd=%h c=1",
                         i, read, count, v);
            end
            ren = 1'b1;
            tick();
            idle();
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_end got e=%b want 1", empty);
        end
    endtask

    task automatic test_back_to_back();
        push(64'hC000);
        for (int i = 1; i < 20; i++) begin
            wen   = 1'b1;
            ren   = 1'b1;
            write = 64'hC000 + 64'(i);
            tick();
            n_cmp++;
            if (read !== 64'hC000 + 64'(i) || count !== 5'd1) begin
                n_bad++;
                $display("FAIL b2b%0d got rd=%h c=%0d want rd=%h c=1",
                         i, read, count, 64'hC000 + 64'(i));
            end
        end
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        idle();
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
